// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

   // FSM encoding; only these three values are ever reachable.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_STALL  = 2'd2
   } arb_state_e;

   localparam int DEF_FIFO_WIDTH = 16;
   localparam int DEF_NUM_REQ    = 4;
   localparam int CNT_W          = 16;

   // Width of a requester index; never below one bit so two requesters still work.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans req starting at ptr, wrapping at NUM_REQ-1.
module rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   winner,
   output logic               found
);

   // First set request at or after ptr wins.
   always_comb begin
      int               idx;
      logic [IDX_W-1:0] idx_v;
      // NOTE: every output gets a default before the loop so no path leaves a value unassigned (no latch).
      gnt    = '0;
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_v = IDX_W'(idx);
         if (!found && req[idx_v]) begin
            found      = 1'b1;
            winner     = idx_v;
            gnt[idx_v] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Grants are throttled by FIFO full/almostfull, the write is registered one
// cycle later, and the FIFO acknowledge two cycles after the grant is routed
// back to the requester that owned the write.
// Optional: define FIFO_ARB_STATS_EN to build saturating per-requester grant counters.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
   parameter int NUM_REQ    = DEF_NUM_REQ
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [FIFO_WIDTH-1:0]         data_in,
   output logic                          wr_en,
   input  logic                          full,
   input  logic                          almostfull,
   input  logic                          wr_ack,
   input  logic                          overflow,
   output logic [NUM_REQ-1:0]            ack_out,
   output logic [NUM_REQ-1:0]            nack_out,
   output logic                          err_overflow,
   output logic [1:0]                    state,
   output logic [NUM_REQ*CNT_W-1:0]      grant_cnt
);

   localparam int IDX_W = idx_width(NUM_REQ);

   arb_state_e              state_q, state_d;
   logic [IDX_W-1:0]        ptr_q, ptr_d;
   logic                    wr_en_q, wr_en_d;
   logic [FIFO_WIDTH-1:0]   data_in_q, data_in_d;
   logic                    own1_vld_q, own1_vld_d;
   logic [IDX_W-1:0]        own1_idx_q, own1_idx_d;
   logic                    own2_vld_q, own2_vld_d;
   logic [IDX_W-1:0]        own2_idx_q, own2_idx_d;
   logic                    err_q, err_d;

   logic [NUM_REQ-1:0]      arb_gnt;
   logic [IDX_W-1:0]        arb_winner;
   logic                    arb_found;
   logic                    req_any;
   logic                    can_grant;
   logic                    grant_ok;
   logic [FIFO_WIDTH-1:0]   sel_data;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req    (req),
      .ptr    (ptr_q),
      .gnt    (arb_gnt),
      .winner (arb_winner),
      .found  (arb_found)
   );

   // Almostfull leaves room for exactly the write already in flight, so no grant then.
   assign req_any   = |req;
   assign can_grant = !full && !(almostfull && wr_en_q);
   assign grant_ok  = arb_found && can_grant && !rst;
   assign gnt       = grant_ok ? arb_gnt : '0;

   // Select the winning requester's word.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_winner == IDX_W'(i)) sel_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
   end

   // Next-state, pointer, write port and owner pipeline.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      wr_en_d    = grant_ok;
      data_in_d  = data_in_q;
      own1_vld_d = grant_ok;
      own1_idx_d = arb_winner;
      own2_vld_d = own1_vld_q;
      own2_idx_d = own1_idx_q;
      err_d      = err_q | overflow;

      if (grant_ok) begin
         data_in_d = sel_data;
         ptr_d     = (arb_winner == IDX_W'(NUM_REQ - 1)) ? '0 : arb_winner + IDX_W'(1);
      end

      if (req_any && !can_grant) state_d = ST_STALL;
      else if (grant_ok)         state_d = ST_ACTIVE;
      else if (!req_any)         state_d = ST_IDLE;
   end

   // Route the FIFO acknowledge to the owner of the write two cycles after its grant.
   always_comb begin
      ack_out  = '0;
      nack_out = '0;
      if (own2_vld_q && !rst) begin
         if (wr_ack) ack_out[own2_idx_q]  = 1'b1;
         else        nack_out[own2_idx_q] = 1'b1;
      end
   end

   // State registers; reset drops any ownership still in flight.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         wr_en_q    <= 1'b0;
         data_in_q  <= '0;
         own1_vld_q <= 1'b0;
         own1_idx_q <= '0;
         own2_vld_q <= 1'b0;
         own2_idx_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         wr_en_q    <= wr_en_d;
         data_in_q  <= data_in_d;
         own1_vld_q <= own1_vld_d;
         own1_idx_q <= own1_idx_d;
         own2_vld_q <= own2_vld_d;
         own2_idx_q <= own2_idx_d;
         err_q      <= err_d;
      end
   end

   assign state        = state_q;
   assign wr_en        = wr_en_q;
   assign data_in      = data_in_q;
   assign err_overflow = err_q;

`ifdef FIFO_ARB_STATS_EN
   logic [CNT_W-1:0] cnt_q [NUM_REQ];
   logic [CNT_W-1:0] cnt_d [NUM_REQ];

   // Count grants per requester, saturating at all-ones.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         cnt_d[i] = cnt_q[i];
         if (gnt[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Pack counters onto the flat output bus.
   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
   end
`else
   assign grant_cnt = '0;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, data word width; SHALL match the FIFO write port.
REQ-002 Parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req  in  NUM_REQ  per-requester write request, level.
REQ-006 req_data  in  NUM_REQ*FIFO_WIDTH  per-requester word; requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-007 gnt  out  NUM_REQ  one-hot/zero, combinational; gnt[i]=1 means req_data slice i is accepted this cycle.
REQ-008 data_in  out  FIFO_WIDTH  registered word to the FIFO.
REQ-009 wr_en  out  1  registered FIFO write strobe.
REQ-010 full, almostfull, wr_ack, overflow  in  1 each  FIFO status and acknowledge.
REQ-011 ack_out  out  NUM_REQ  one-cycle pulse to the owner of an acknowledged write.
REQ-012 nack_out  out  NUM_REQ  one-cycle pulse to the owner of a write the FIFO did not acknowledge.
REQ-013 err_overflow  out  1  sticky; set by overflow=1.
REQ-014 state  out  2  current FSM state encoding.
REQ-015 grant_cnt  out  NUM_REQ*16  per-requester grant counters (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE=0, ACTIVE=1, STALL=2; no other encoding is reachable.
REQ-017 can_grant = !full && !(almostfull && wr_en); a grant SHALL occur only when can_grant=1 and |req=1.
REQ-018 Transitions: IDLE->ACTIVE when a grant occurs; any state->STALL when |req && !can_grant; STALL->ACTIVE on a grant; ACTIVE->IDLE when !|req; STALL->IDLE when !|req.
REQ-019 Arbitration SHALL be round-robin: search begins at pointer ptr, wrapping from NUM_REQ-1 to 0; first set req wins.
REQ-020 After a grant to i, ptr SHALL become (i+1) mod NUM_REQ; without a grant, ptr SHALL hold.
REQ-021 Grant at cycle N SHALL produce wr_en=1 and data_in=granted word in cycle N+1; at most one write per cycle.
REQ-022 Without a grant, wr_en SHALL be 0 next cycle and data_in SHALL hold its last value.
REQ-023 The owner index SHALL be pipelined two stages, aligning with wr_ack at N+2.
REQ-024 At N+2, wr_ack=1 SHALL pulse ack_out[owner]; wr_ack=0 with a write issued at N+1 SHALL pulse nack_out[owner]; both SHALL be combinational on wr_ack.
REQ-025 wr_ack=1 with no write in flight SHALL be ignored (no ack_out pulse).
REQ-026 REQ-017 guarantees no overflow; any overflow=1 SHALL set err_overflow, cleared only by rst.
REQ-027 Back-to-back grants to one requester SHALL occur only when no other req is set.

Reset
REQ-028 On rst: state=IDLE, ptr=0, wr_en=0, data_in=0, owner pipeline invalid, err_overflow=0, grant_cnt=0; gnt/ack_out/nack_out SHALL be 0 while rst=1.
REQ-029 rst mid-transfer SHALL discard in-flight ownership; a later wr_ack SHALL produce no ack_out.

Configuration
REQ-030 Macro FIFO_ARB_STATS_EN defined: per-requester 16-bit counters SHALL increment on each gnt[i] and saturate at 16'hFFFF.
REQ-031 Macro absent: counters SHALL not be built; grant_cnt SHALL be driven 0; all other behaviour identical.

Structure
REQ-032 Package fifo_arb_pkg SHALL hold the FSM state enum, default FIFO_WIDTH/NUM_REQ constants and the counter width (16).
REQ-033 Sub-module rr_arbiter (req, ptr -> one-hot gnt, winner index) SHALL be a separate combinational module.

Verification
REQ-034 req=4'b1111 continuously, FIFO never full -> gnt order 0,1,2,3,0; wr_en=1 every cycle from cycle 1; ack_out follows the same order two cycles after each gnt.
REQ-035 Fill FIFO (depth 8) from requester 2 only -> almostfull then full stall grants, state=STALL, overflow never asserted, exactly 8 ack_out[2] pulses.
REQ-036 req=4'b0101 -> gnt alternates 0,2,0,2; ptr wraps correctly; grant_cnt[0]=grant_cnt[2] after an even number of grants (FIFO_ARB_STATS_EN defined).
REQ-037 Force wr_ack=0 for one write from requester 1 -> nack_out[1] one cycle pulse, ack_out=0 that cycle.
REQ-038 Assert rst between grant and wr_ack -> no ack_out/nack_out; outputs at reset values; err_overflow=0.
REQ-039 Inject overflow=1 for one cycle -> err_overflow=1 and held until rst.
